// File: rtl/sw_debounce8.sv
// Two-flop synchroniser plus per-channel debounce for 8 switches and an enable.
// Outputs are registered. chg pulses for one cycle on any edge where an output flips.
module sw_debounce8 #(
  parameter int DB_CYCLES = 4096,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw_in,
  input  logic       en_in,
  output logic [7:0] sw_out,
  output logic       en_out,
  output logic       chg
);

  localparam int NCH = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1_q, s2_q;
  logic [NCH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic chg_q, chg_d;

  // Bit 8 carries the enable so all nine channels share one loop.
  assign raw = {en_in, sw_in};

  always_comb begin
    out_d = out_q;
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c] = '0;
      if (s2_q[c] != out_q[c]) begin
        if (cnt_q[c] == CNT_MAX) begin
          out_d[c] = s2_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
    chg_d = |(out_d ^ out_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
      chg_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      out_q <= out_d;
      chg_q <= chg_d;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign sw_out = out_q[7:0];
  assign en_out = out_q[8];
  assign chg    = chg_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Directed bench: a DB_CYCLES=4 instance driven from a per-cycle vector table,
// plus hand-written sequences for reset behaviour and a DB_CYCLES=1 instance.
module tb_sw_debounce8;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw_in;
  logic       en_in;
  logic [7:0] sw_out;
  logic       en_out;
  logic       chg;

  logic [7:0] sw1_in;
  logic       en1_in;
  logic [7:0] sw1_out;
  logic       en1_out;
  logic       chg1;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [7:0] sw;
    logic       en;
    logic [7:0] exp_sw;
    logic       exp_en;
    logic       exp_chg;
  } vec_t;

  vec_t vecs[$];

  sw_debounce8 #(.DB_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .en_in  (en_in),
    .sw_out (sw_out),
    .en_out (en_out),
    .chg    (chg)
  );

  sw_debounce8 #(.DB_CYCLES(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw1_in),
    .en_in  (en1_in),
    .sw_out (sw1_out),
    .en_out (en1_out),
    .chg    (chg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got sw=%h en=%b chg=%b, expected sw=%h en=%b chg=%b",
               name, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic [7:0] s, input logic e, input logic [7:0] es,
                     input logic ee, input logic ec);
    vec_t v;
    v.sw = s; v.en = e; v.exp_sw = es; v.exp_en = ee; v.exp_chg = ec;
    vecs.push_back(v);
  endtask

  // Hold an input for n edges; output holds old value for n-1 edges then flips with chg.
  task automatic add_flip(input logic [7:0] s, input logic e, input logic [7:0] old_sw,
                          input logic old_en);
    for (int i = 0; i < 5; i++) add(s, e, old_sw, old_en, 1'b0);
    add(s, e, s, e, 1'b1);
    add(s, e, s, e, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    sw_in   = 8'hFF;
    en_in   = 1'b1;
    sw1_in  = 8'h00;
    en1_in  = 1'b0;

    // Reset held with inputs high: outputs must stay at zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", {sw_out, en_out, chg}, 10'b0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 6)       check("post_reset_wait", {sw_out, en_out, chg}, 10'b0);
      else if (e == 6) check("post_reset_flip", {sw_out, en_out, chg}, {8'hFF, 1'b1, 1'b1});
      else             check("post_reset_hold", {sw_out, en_out, chg}, {8'hFF, 1'b1, 1'b0});
    end

    // Back to idle zero.
    rst_n = 1'b0;
    sw_in = 8'h00;
    en_in = 1'b0;
    tick();
    check("reset_clear", {sw_out, en_out, chg}, 10'b0);
    rst_n = 1'b1;

    // Clean step 00 -> 10 and back.
    add_flip(8'h10, 1'b0, 8'h00, 1'b0);
    add_flip(8'h00, 1'b0, 8'h10, 1'b0);
    // Bounce on bit 3: 3 high, 1 low, 2 high, then low.
    add(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    // Final stable hold of bit 3.
    add_flip(8'h08, 1'b0, 8'h00, 1'b0);
    add_flip(8'h00, 1'b0, 8'h08, 1'b0);
    // Two bits together: single chg pulse.
    add_flip(8'h81, 1'b0, 8'h00, 1'b0);
    // Bit 2 rises, enable one clock later: chg on consecutive cycles.
    add(8'h85, 1'b0, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add(8'h85, 1'b1, 8'h81, 1'b0, 1'b0);
    add(8'h85, 1'b1, 8'h85, 1'b0, 1'b1);
    add(8'h85, 1'b1, 8'h85, 1'b1, 1'b1);
    add(8'h85, 1'b1, 8'h85, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      sw_in = vecs[i].sw;
      en_in = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), {sw_out, en_out, chg},
            {vecs[i].exp_sw, vecs[i].exp_en, vecs[i].exp_chg});
    end

    // Mid-count reset: outputs clear with no clock edge, then full latency again.
    sw_in = 8'h40;
    en_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("midcount_before", {sw_out, en_out, chg}, {8'h85, 1'b1, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("midcount_async", {sw_out, en_out, chg}, 10'b0);
    tick();
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 6)       check("midcount_wait", {sw_out, en_out, chg}, 10'b0);
      else if (e == 6) check("midcount_flip", {sw_out, en_out, chg}, {8'h40, 1'b0, 1'b1});
      else             check("midcount_hold", {sw_out, en_out, chg}, {8'h40, 1'b0, 1'b0});
    end

    // DB_CYCLES=1: three-edge latency, single-cycle glitch passes through.
    sw1_in = 8'h01;
    tick();
    check("db1_e1", {sw1_out, en1_out, chg1}, 10'b0);
    tick();
    check("db1_e2", {sw1_out, en1_out, chg1}, 10'b0);
    tick();
    check("db1_e3", {sw1_out, en1_out, chg1}, {8'h01, 1'b0, 1'b1});
    tick();
    check("db1_e4", {sw1_out, en1_out, chg1}, {8'h01, 1'b0, 1'b0});
    sw1_in = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    check("db1_low", {sw1_out, en1_out, chg1}, 10'b0);
    sw1_in = 8'h01;
    tick();
    sw1_in = 8'h00;
    tick();
    check("db1_glitch_g2", {sw1_out, en1_out, chg1}, 10'b0);
    tick();
    check("db1_glitch_g3", {sw1_out, en1_out, chg1}, {8'h01, 1'b0, 1'b1});
    tick();
    check("db1_glitch_g4", {sw1_out, en1_out, chg1}, {8'h00, 1'b0, 1'b1});
    tick();
    check("db1_glitch_g5", {sw1_out, en1_out, chg1}, 10'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
